s_1: RTL and testbench



---
 rtl/s_1.sv | 42 ++++
 tb/tb_s_1.sv | 125 ++++++++++++
 2 files changed

// File: rtl/s_1.sv
// Registered SHA-256 big-sigma-1 stage: s1 = ROTR6(x) ^ ROTR11(x) ^ ROTR25(x).
// A valid strobe travels alongside so round pipelines can track occupancy.
module s_1 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s1,
    output logic             out_valid
);

    localparam int ROT_A = 6;
    localparam int ROT_B = 11;
    localparam int ROT_C = 25;

    logic [WIDTH-1:0] rot_a;
    logic [WIDTH-1:0] rot_b;
    logic [WIDTH-1:0] rot_c;
    logic [WIDTH-1:0] sigma;

    // Rotations are pure wiring; the only logic in front of the register is a 3-input XOR per bit.
    always_comb begin
        rot_a = (x >> ROT_A) | (x << (WIDTH - ROT_A));
        rot_b = (x >> ROT_B) | (x << (WIDTH - ROT_B));
        rot_c = (x >> ROT_C) | (x << (WIDTH - ROT_C));
        sigma = rot_a ^ rot_b ^ rot_c;
    end

    // s1 loads every cycle regardless of in_valid; consumers qualify it with out_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1        <= '0;
            out_valid <= 1'b0;
        end else begin
            s1        <= sigma;
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_s_1.sv
// Scoreboard bench for s_1: stimulus pushes expected results, a negedge monitor pops and compares.
// Random words are checked against a bit-index model of big-sigma-1.
module tb_s_1;

    typedef struct {
        logic [31:0] s1;
        logic        valid;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] x;
    logic        in_valid;
    logic [31:0] s1;
    logic        out_valid;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    s_1 #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x        (x),
        .in_valid (in_valid),
        .s1       (s1),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bit i of the result is the XOR of three input bits at fixed modular offsets.
    function automatic logic [31:0] sigma1_model(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            r[i] = w[(i + 6) % 32] ^ w[(i + 11) % 32] ^ w[(i + 25) % 32];
        return r;
    endfunction

    // Drive one cycle of inputs, then record what the DUT must show after that edge.
    task automatic applyStimulus(input logic rst_val, input logic [31:0] x_val,
                                 input logic v_val, input logic [31:0] exp_s1,
                                 input logic exp_v, input string name);
        exp_t e;
        rst_n    = rst_val;
        x        = x_val;
        in_valid = v_val;
        @(posedge clk);
        e.s1    = exp_s1;
        e.valid = exp_v;
        e.name  = name;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (s1 !== e.s1 || out_valid !== e.valid) begin
            failures++;
            $display("[TB] FAIL %s: got s1=%08h out_valid=%b, expected s1=%08h out_valid=%b",
                     e.name, s1, out_valid, e.s1, e.valid);
        end
    endtask

    // Monitor: the DUT presents a result after every edge, so one entry is consumed per cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput(e);
        end
    end

    initial begin
        logic [31:0] rx;
        logic        rv;
        logic        rr;
        int          wait_cycles;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        x        = '0;
        in_valid = 1'b0;

        applyStimulus(1'b0, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0, "reset");
        applyStimulus(1'b1, 32'h0000FFFF, 1'b1, 32'h039FFC60, 1'b1, "known_vector");
        applyStimulus(1'b1, 32'h0000FFFF, 1'b1, 32'h039FFC60, 1'b1, "known_vector_hold");
        applyStimulus(1'b1, 32'h00000001, 1'b1, 32'h04200080, 1'b1, "wrap_lsb");
        applyStimulus(1'b1, 32'h80000000, 1'b1, 32'h02100040, 1'b1, "wrap_msb");
        applyStimulus(1'b1, 32'h00000000, 1'b1, 32'h00000000, 1'b1, "corner_zero");
        applyStimulus(1'b1, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, "corner_ones");
        applyStimulus(1'b1, 32'h00000001, 1'b1, 32'h04200080, 1'b1, "stream_0");
        applyStimulus(1'b1, 32'h0000FFFF, 1'b0, 32'h039FFC60, 1'b0, "stream_1");
        applyStimulus(1'b1, 32'h80000000, 1'b1, 32'h02100040, 1'b1, "stream_2");
        applyStimulus(1'b0, 32'h12345678, 1'b1, 32'h00000000, 1'b0, "mid_reset");

        for (int n = 0; n < 1000; n++) begin
            rx = $urandom;
            rv = 1'($urandom_range(0, 1));
            rr = ($urandom_range(0, 49) == 0);
            if (rr)
                applyStimulus(1'b0, rx, rv, 32'h00000000, 1'b0, "random_reset");
            else
                applyStimulus(1'b1, rx, rv, sigma1_model(rx), rv, "random");
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
